instruction_loader: RTL



---
 rtl/instruction_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// Instruction-memory program loader: unpacks a length-prefixed byte stream into
// 20-bit words, writes them from address 0 and holds the CPU in reset until done.
module instruction_loader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [7:0]             in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [ADDR_WIDTH-1:0]  mem_address_o,
  output logic [INSTR_WIDTH-1:0] mem_data_o,
  output logic                   mem_wren_o,
  output logic                   cpu_reset_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [ADDR_WIDTH-1:0]  words_loaded_o
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [11:0]            hi_q, hi_d;      // word bits [19:8] gathered by B0/B1
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0]  count_q, count_d;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  count_inc;
  logic                   fire;

  // Status outputs are pure functions of state, so ready never loops back through valid.
  assign in_ready_o     = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                          (state_q == B0) || (state_q == B1) || (state_q == B2);
  assign mem_wren_o     = (state_q == WRITE);
  assign busy_o         = (state_q != IDLE) && (state_q != DONE);
  assign done_o         = (state_q == DONE);
  assign cpu_reset_o    = (state_q != DONE);
  assign error_o        = err_q;
  assign words_loaded_o = count_q;
  assign mem_address_o  = addr_q;
  assign mem_data_o     = data_q;

  assign fire      = in_valid_i && in_ready_o;
  assign count_inc = count_q + ADDR_WIDTH'(1);

  always_comb begin
    // NOTE: every next-state value defaults to its current register first so no
    // path through the case statement can infer a latch.
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = LEN_HI;
          len_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      LEN_HI: begin
        if (fire) begin
          len_d[15:8] = in_data_i;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (fire) begin
          len_d[7:0] = in_data_i;
          state_d    = ({len_q[15:8], in_data_i} == 16'd0) ? DONE : B0;
        end
      end
      B0: begin
        if (fire) begin
          hi_d[11:8] = in_data_i[3:0];
          if (in_data_i[7:4] != 4'd0) err_d = 1'b1;
          state_d = B1;
        end
      end
      B1: begin
        if (fire) begin
          hi_d[7:0] = in_data_i;
          state_d   = B2;
        end
      end
      B2: begin
        if (fire) begin
          // Address and data are registered here so they are stable for the whole WRITE cycle.
          addr_d  = count_q;
          data_d  = INSTR_WIDTH'({hi_q, in_data_i});
          state_d = WRITE;
        end
      end
      WRITE: begin
        count_d = count_inc;
        state_d = (count_inc == ADDR_WIDTH'(len_q)) ? DONE : B0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see
  // the pre-edge values of each other, exactly like the flops they model.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule
